// File: rtl/sha3_pad.sv
// SHA3 message padder: packs 32-bit little-endian words into RATE_BYTES rate blocks
// and applies the pad10*1 padding with domain byte DS. Define SHA3_PAD_DS_EN for a runtime cfg_ds input.
module sha3_pad #(
  parameter int RATE_BYTES = 136
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
`ifdef SHA3_PAD_DS_EN
  input  logic [7:0]              cfg_ds,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic [2:0]              in_nbytes,
  input  logic                    in_last,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_last
);

  localparam int NW = RATE_BYTES / 4;

  typedef enum logic [1:0] {FILL, OUT, XTRA} state_t;

  state_t                 state_q, state_d;
  logic [NW-1:0][31:0]    buf_q, buf_d;
  logic [5:0]             wcnt_q;
  logic                   extra_q, last_q;
  logic [7:0]             ds_in, ds_x;
  logic [31:0]            word_fill;
  logic [2:0]             nb_eff;
  logic                   acc, at_end, full_last, pad;

`ifdef SHA3_PAD_DS_EN
  logic [7:0] ds_q;
  assign ds_in = cfg_ds;
  assign ds_x  = ds_q;
  // DS must survive until a possible trailing extra block is built
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                ds_q <= 8'h06;
    else if (acc && in_last)     ds_q <= cfg_ds;
  end
`else
  assign ds_in = 8'h06;
  assign ds_x  = 8'h06;
`endif

  assign in_ready  = (state_q == FILL) && !wb_rst_i;
  assign blk_valid = (state_q == OUT) && !wb_rst_i;
  assign blk_data  = buf_q;
  assign blk_last  = last_q;

  assign acc       = in_valid && in_ready;
  assign at_end    = (wcnt_q == 6'(NW - 1));
  assign full_last = in_last && (in_nbytes >= 3'd4);
  assign pad       = in_last && !(full_last && at_end);
  assign nb_eff    = in_last ? in_nbytes : 3'd4;

  // Valid bytes pass, first invalid byte carries DS, stale bytes above are zeroed
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_fill[8*b +: 8] = (3'(b) < nb_eff)  ? in_data[8*b +: 8] :
                                 (3'(b) == nb_eff) ? ds_in : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      FILL: if (acc) begin
        for (int s = 0; s < NW; s++) begin
          if (int'(wcnt_q) == s)                 buf_d[s] = word_fill;
          if (full_last && int'(wcnt_q) + 1 == s) buf_d[s] = {24'h0, ds_in};
        end
        if (pad) buf_d[NW-1][31:24] = buf_d[NW-1][31:24] | 8'h80;
        if (at_end || in_last) state_d = OUT;
      end
      OUT: if (blk_ready) begin
        if (extra_q) state_d = XTRA;
        else begin
          buf_d   = '0;
          state_d = FILL;
        end
      end
      XTRA: begin
        buf_d               = '0;
        buf_d[0][7:0]       = ds_x;
        buf_d[NW-1][31:24]  = buf_d[NW-1][31:24] | 8'h80;
        state_d             = OUT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= FILL;
      buf_q   <= '0;
      wcnt_q  <= '0;
      extra_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      if (acc) begin
        wcnt_q  <= wcnt_q + 6'd1;
        last_q  <= pad;
        extra_q <= full_last && at_end;
      end else if (state_q == OUT && blk_ready && !extra_q) begin
        wcnt_q <= '0;
        last_q <= 1'b0;
      end else if (state_q == XTRA) begin
        wcnt_q  <= '0;
        last_q  <= 1'b1;
        extra_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_pad.sv
// Directed bench for sha3_pad with hand-built expected rate blocks (RATE_BYTES=136).
module tb_sha3_pad;
  localparam int RB = 136;
  localparam int NW = RB / 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [31:0]     in_data = '0;
  logic [2:0]      in_nbytes = '0;
  logic            in_ready, blk_valid, blk_last;
  logic [8*RB-1:0] blk_data;
`ifdef SHA3_PAD_DS_EN
  logic [7:0]      cfg_ds = 8'h06;
`endif

  int n_chk = 0, n_pass = 0;
  logic [7:0] eb [RB];

  sha3_pad #(.RATE_BYTES(RB)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
`ifdef SHA3_PAD_DS_EN
    .cfg_ds(cfg_ds),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbytes(in_nbytes), .in_last(in_last), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last));

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic exp_clr();
    for (int i = 0; i < RB; i++) eb[i] = 8'h00;
  endtask

  // Compares the first differing word (word 0 when the block matches)
  task automatic chk_blk(input string tag);
    int w;
    logic [31:0] ew;
    w = 0;
    for (int i = NW - 1; i >= 0; i--)
      if (blk_data[32*i +: 32] !== {eb[4*i+3], eb[4*i+2], eb[4*i+1], eb[4*i]}) w = i;
    ew = {eb[4*w+3], eb[4*w+2], eb[4*w+1], eb[4*w]};
    chk($sformatf("%s_w%0d", tag, w), blk_data[32*w +: 32], ew);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_blk(input string tag, input logic exp_last, input int hold);
    int n;
    n = 0;
    while (!blk_valid && n < 100) begin tick(); n++; end
    if (!blk_valid) begin
      chk({tag, "_timeout"}, 32'(blk_valid), 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk_blk($sformatf("%s_hold%0d", tag, h));
      chk($sformatf("%s_hold%0d_in_ready", tag, h), 32'(in_ready), 32'd0);
      tick();
    end
    chk_blk(tag);
    chk({tag, "_last"}, 32'(blk_last), 32'(exp_last));
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    exp_clr();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_blk_last", 32'(blk_last), 32'd0);
    chk_blk("rst_data");
    wb_rst_i = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Empty message
    send(32'hDEADBEEF, 3'd0, 1'b1);
    exp_clr(); eb[0] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("empty", 1'b1, 0);
    chk("empty_in_ready", 32'(in_ready), 32'd1);

    // "abc" with 5 cycles of backpressure
    send(32'h00636261, 3'd3, 1'b1);
    exp_clr(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("abc", 1'b1, 5);
    chk("abc_in_ready_after", 32'(in_ready), 32'd1);

    // 135 bytes: DS and 0x80 share the last byte; stale byte in_data[31:24] must drop
    for (int i = 0; i < 33; i++) send(32'hA5A5A5A5, 3'd4, 1'b0);
    send(32'hFFA5A5A5, 3'd3, 1'b1);
    exp_clr();
    for (int i = 0; i < RB - 1; i++) eb[i] = 8'hA5;
    eb[RB-1] = 8'h86;
    get_blk("b135", 1'b1, 0);

    // 136 bytes: unpadded full block then extra padding block
    for (int i = 0; i < 33; i++) send(32'hA5A5A5A5, 3'd4, 1'b0);
    send(32'hA5A5A5A5, 3'd4, 1'b1);
    exp_clr();
    for (int i = 0; i < RB; i++) eb[i] = 8'hA5;
    get_blk("b136_1", 1'b0, 0);
    chk("b136_xtra_in_ready", 32'(in_ready), 32'd0);
    exp_clr(); eb[0] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("b136_2", 1'b1, 0);
    chk("b136_in_ready_after", 32'(in_ready), 32'd1);

    // 132 bytes: DS lands in the final slot byte 0, 0x80 in its byte 3
    for (int i = 0; i < 32; i++) send(32'h5A5A5A5A, 3'd4, 1'b0);
    send(32'h5A5A5A5A, 3'd4, 1'b1);
    exp_clr();
    for (int i = 0; i < 132; i++) eb[i] = 8'h5A;
    eb[132] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("b132", 1'b1, 0);

    // Non-last word with nbytes=0 is a full word; full last word puts DS in next slot
    send(32'h44332211, 3'd0, 1'b0);
    send(32'h88776655, 3'd4, 1'b1);
    exp_clr();
    eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h33; eb[3] = 8'h44;
    eb[4] = 8'h55; eb[5] = 8'h66; eb[6] = 8'h77; eb[7] = 8'h88;
    eb[8] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("b8", 1'b1, 0);

    // One valid byte; upper stale bytes zeroed
    send(32'hDDCCBBAA, 3'd1, 1'b1);
    exp_clr(); eb[0] = 8'hAA; eb[1] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("b1", 1'b1, 0);

    // Reset mid-fill discards everything
    for (int i = 0; i < 10; i++) send(32'h12345678, 3'd4, 1'b0);
    wb_rst_i = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_rst_i = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (blk_valid) seen = 1'b1;
        tick();
      end
      chk("midrst_no_blk", 32'(seen), 32'd0);
    end
    send(32'h00636261, 3'd3, 1'b1);
    exp_clr(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h06; eb[RB-1] = 8'h80;
    get_blk("abc2", 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
